// File: rtl/onchip_sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sram_arb_pkg : shared types and default widths for the SRAM port arbiter
// Revision     : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int c_ADDR_W = 10;
  localparam int c_DATA_W = 32;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  typedef logic master_idx_t;

endpackage
`default_nettype wire

// File: rtl/onchip_sram_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-requester grant logic, round-robin or fixed M0 priority
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic [1:0]  i_req,
  input  master_idx_t i_last_grant,
  input  logic        i_prio_m0,
  output logic [1:0]  o_gnt
);

  // On contention the master that was not granted last wins
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_prio_m0 || (i_last_grant == 1'b1)) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/onchip_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// onchip_sram_port_arbiter : shares SRAM port 2 between two Avalon-MM masters
// Optional bus locking is enabled by defining SRAM_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W,
  parameter int DATA_W      = c_DATA_W,
  parameter int M0_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
`ifdef SRAM_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_clken,
  input  logic [DATA_W-1:0]   sram_readdata
);

  lock_state_t r_state;
  lock_state_t w_state_nxt;
  master_idx_t r_last_grant;
  master_idx_t r_rd_owner;
  logic        r_rd_pending;
  logic [1:0]  w_req;
  logic [1:0]  w_req_masked;
  logic [1:0]  w_arb_gnt;
  logic [1:0]  w_gnt;
  logic        w_any_gnt;
  logic        w_sel_m1;
  logic        w_sel_write;

  assign w_req        = {m1_read | m1_write, m0_read | m0_write};
  assign w_req_masked = {w_req[1] & (r_state != LOCK0), w_req[0] & (r_state != LOCK1)};

  rr_arbiter2 u_arb (
    .i_req        (w_req_masked),
    .i_last_grant (r_last_grant),
    .i_prio_m0    (M0_PRIORITY != 0),
    .o_gnt        (w_arb_gnt)
  );

  // Reset gates the grant so the port is quiet while reset_n is low
  assign w_gnt       = w_arb_gnt & {2{reset_n}};
  assign w_any_gnt   = |w_gnt;
  assign w_sel_m1    = w_gnt[1];
  assign w_sel_write = w_sel_m1 ? m1_write : m0_write;

  assign m0_waitrequest  = ~w_gnt[0];
  assign m1_waitrequest  = ~w_gnt[1];
  assign sram_address    = w_sel_m1 ? m1_address    : m0_address;
  assign sram_writedata  = w_sel_m1 ? m1_writedata  : m0_writedata;
  assign sram_byteenable = w_sel_m1 ? m1_byteenable : m0_byteenable;
  assign sram_chipselect = w_any_gnt;
  assign sram_write      = w_any_gnt & w_sel_write;
  assign sram_clken      = 1'b1;

  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;
  assign m0_readdatavalid = r_rd_pending & (r_rd_owner == 1'b0);
  assign m1_readdatavalid = r_rd_pending & (r_rd_owner == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      if (w_any_gnt) r_last_grant <= w_sel_m1;
      r_rd_pending <= w_any_gnt & ~w_sel_write;
      if (w_any_gnt & ~w_sel_write) r_rd_owner <= w_sel_m1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FREE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef SRAM_ARB_LOCK_EN
    // Inside LOCKi only master i is granted, so a dropped lock releases
    // whether master i is idle or being granted this cycle
    case (r_state)
      FREE: begin
        if (w_gnt[0] && m0_lock)      w_state_nxt = LOCK0;
        else if (w_gnt[1] && m1_lock) w_state_nxt = LOCK1;
      end
      LOCK0:   if (!m0_lock) w_state_nxt = FREE;
      LOCK1:   if (!m1_lock) w_state_nxt = FREE;
      default: w_state_nxt = FREE;
    endcase
`else
    w_state_nxt = FREE;
`endif
  end

`ifndef SYNTHESIS
  a_m0_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write))
    else $error("m0_read and m0_write both high; handled as a write");
  a_m1_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write))
    else $error("m1_read and m1_write both high; handled as a write");
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_onchip_sram_port_arbiter : table-driven bench with a behavioural SRAM
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_sram_port_arbiter;

  localparam logic [1:0] OP_I = 2'd0;
  localparam logic [1:0] OP_R = 2'd1;
  localparam logic [1:0] OP_W = 2'd2;
  localparam int         NVEC = 17;

  typedef struct {
    logic [1:0]  op0;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [1:0]  op1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [5:0]  fl;   // {wait0, wait1, cs, sram_write, rdv0, rdv1}
    logic [9:0]  ea;
    logic [31:0] erd;
    logic [31:0] ewd;
    logic [3:0]  ebe;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
`ifdef SRAM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif
  logic [9:0]  sram_address;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [31:0] sram_writedata;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_readdata;

  logic [31:0] mem [0:1023];
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        tbl [NVEC];

  always #5 clk = ~clk;

  // Behavioural SRAM port: registered address, one-cycle read latency
  always @(posedge clk) begin
    if (sram_chipselect && sram_clken) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
      end else begin
        sram_readdata <= mem[sram_address];
      end
    end
  end

  onchip_sram_port_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef SRAM_ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
`endif
    .sram_address     (sram_address),
    .sram_chipselect  (sram_chipselect),
    .sram_write       (sram_write),
    .sram_writedata   (sram_writedata),
    .sram_byteenable  (sram_byteenable),
    .sram_clken       (sram_clken),
    .sram_readdata    (sram_readdata)
  );

  function automatic vec_t vec(input logic [1:0] op0, input logic [9:0] a0, input logic [31:0] d0,
                               input logic [3:0] be0, input logic [1:0] op1, input logic [9:0] a1,
                               input logic [31:0] d1, input logic [3:0] be1, input logic [5:0] fl,
                               input logic [9:0] ea, input logic [31:0] erd, input logic [31:0] ewd,
                               input logic [3:0] ebe);
    vec_t v;
    v.op0 = op0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.op1 = op1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
    v.fl = fl; v.ea = ea; v.erd = erd; v.ewd = ewd; v.ebe = ebe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic [3:0] be0, input logic [1:0] op1, input logic [9:0] a1,
                       input logic [31:0] d1, input logic [3:0] be1);
    m0_read = (op0 == OP_R); m0_write = (op0 == OP_W);
    m0_address = a0; m0_writedata = d0; m0_byteenable = be0;
    m1_read = (op1 == OP_R); m1_write = (op1 == OP_W);
    m1_address = a1; m1_writedata = d1; m1_byteenable = be1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h001] = 32'h1111_1111;
    mem[10'h002] = 32'h2222_2222;
    mem[10'h003] = 32'h3333_3333;
    mem[10'h005] = 32'hDEAD_BEEF;
    sram_readdata = 32'h0;

    tbl[0]  = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0, 6'b110000, 10'h000, 32'h0, 32'h0, 4'h0);
    tbl[1]  = vec(OP_W, 10'h010, 32'hA0A0_A0A0, 4'hF, OP_W, 10'h020, 32'hB1B1_B1B1, 4'hF, 6'b011100, 10'h010, 32'h0, 32'hA0A0_A0A0, 4'hF);
    tbl[2]  = vec(OP_W, 10'h010, 32'hA0A0_A0A0, 4'hF, OP_W, 10'h020, 32'hB1B1_B1B1, 4'hF, 6'b101100, 10'h020, 32'h0, 32'hB1B1_B1B1, 4'hF);
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[2];
    tbl[5]  = vec(OP_R, 10'h010, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0, 6'b011000, 10'h010, 32'h0, 32'h0, 4'h0);
    tbl[6]  = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_R, 10'h020, 32'h0, 4'hF, 6'b101010, 10'h020, 32'hA0A0_A0A0, 32'h0, 4'h0);
    tbl[7]  = vec(OP_R, 10'h001, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0, 6'b011001, 10'h001, 32'hB1B1_B1B1, 32'h0, 4'h0);
    tbl[8]  = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_R, 10'h002, 32'h0, 4'hF, 6'b101010, 10'h002, 32'h1111_1111, 32'h0, 4'h0);
    tbl[9]  = vec(OP_R, 10'h003, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0, 6'b011001, 10'h003, 32'h2222_2222, 32'h0, 4'h0);
    tbl[10] = vec(OP_R, 10'h005, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0, 6'b011010, 10'h005, 32'h3333_3333, 32'h0, 4'h0);
    tbl[11] = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0, 6'b110010, 10'h000, 32'hDEAD_BEEF, 32'h0, 4'h0);
    tbl[12] = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_W, 10'h3FF, 32'hAABB_CCDD, 4'b0101, 6'b101100, 10'h3FF, 32'h0, 32'hAABB_CCDD, 4'b0101);
    tbl[13] = vec(OP_R, 10'h3FF, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0, 6'b011000, 10'h3FF, 32'h0, 32'h0, 4'h0);
    tbl[14] = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0, 6'b110010, 10'h000, 32'h00BB_00DD, 32'h0, 4'h0);
    tbl[15] = vec(OP_R, 10'h001, 32'h0, 4'hF, OP_R, 10'h002, 32'h0, 4'hF, 6'b101000, 10'h002, 32'h0, 32'h0, 4'h0);
    tbl[16] = vec(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0, 6'b110001, 10'h000, 32'h2222_2222, 32'h0, 4'h0);

`ifdef SRAM_ARB_LOCK_EN
    m0_lock = 1'b0;
    m1_lock = 1'b0;
`endif
    // Requests held during reset must still see waitrequest and a quiet port
    reset_n = 1'b0;
    drive(OP_R, 10'h005, 32'h0, 4'hF, OP_W, 10'h006, 32'h1234_5678, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_waitrequest", {31'b0, m0_waitrequest}, 32'd1);
    chk("rst_m1_waitrequest", {31'b0, m1_waitrequest}, 32'd1);
    chk("rst_chipselect", {31'b0, sram_chipselect}, 32'd0);
    chk("rst_sram_write", {31'b0, sram_write}, 32'd0);
    chk("rst_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    chk("rst_clken", {31'b0, sram_clken}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      if (i == 0) reset_n = 1'b1;
      drive(tbl[i].op0, tbl[i].a0, tbl[i].d0, tbl[i].be0, tbl[i].op1, tbl[i].a1, tbl[i].d1, tbl[i].be1);
      @(negedge clk);
      chk($sformatf("v%0d_m0_waitrequest", i), {31'b0, m0_waitrequest}, {31'b0, tbl[i].fl[5]});
      chk($sformatf("v%0d_m1_waitrequest", i), {31'b0, m1_waitrequest}, {31'b0, tbl[i].fl[4]});
      chk($sformatf("v%0d_chipselect", i), {31'b0, sram_chipselect}, {31'b0, tbl[i].fl[3]});
      chk($sformatf("v%0d_sram_write", i), {31'b0, sram_write}, {31'b0, tbl[i].fl[2]});
      chk($sformatf("v%0d_m0_rdv", i), {31'b0, m0_readdatavalid}, {31'b0, tbl[i].fl[1]});
      chk($sformatf("v%0d_m1_rdv", i), {31'b0, m1_readdatavalid}, {31'b0, tbl[i].fl[0]});
      if (tbl[i].fl[3]) chk($sformatf("v%0d_sram_address", i), {22'b0, sram_address}, {22'b0, tbl[i].ea});
      if (tbl[i].fl[2]) begin
        chk($sformatf("v%0d_sram_writedata", i), sram_writedata, tbl[i].ewd);
        chk($sformatf("v%0d_sram_byteenable", i), {28'b0, sram_byteenable}, {28'b0, tbl[i].ebe});
      end
      if (tbl[i].fl[1]) chk($sformatf("v%0d_m0_readdata", i), m0_readdata, tbl[i].erd);
      if (tbl[i].fl[0]) chk($sformatf("v%0d_m1_readdata", i), m1_readdata, tbl[i].erd);
    end

    // Reset lands in the cycle after an M1 read grant: its data valid is lost
    next_cycle();
    drive(OP_I, 10'h000, 32'h0, 4'h0, OP_R, 10'h002, 32'h0, 4'hF);
    @(negedge clk);
    chk("midrd_m1_granted", {31'b0, m1_waitrequest}, 32'd0);
    next_cycle();
    reset_n = 1'b0;
    drive(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0);
    @(negedge clk);
    chk("midrd_rdv_dropped", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrd_no_reissue", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    next_cycle();
    drive(OP_W, 10'h030, 32'h1234_5678, 4'hF, OP_W, 10'h031, 32'h8765_4321, 4'hF);
    @(negedge clk);
    chk("midrd_first_contention_m0", {30'b0, m1_waitrequest, m0_waitrequest}, 32'd2);
    next_cycle();
    drive(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0);
    @(negedge clk);
    chk("midrd_idle_quiet", {31'b0, sram_chipselect}, 32'd0);

`ifdef SRAM_ARB_LOCK_EN
    // M1 wins the first contention (M0 was last), locks, and holds for 4 writes
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      m1_lock = 1'b1;
      drive(OP_R, 10'h005, 32'h0, 4'hF, OP_W, 10'h100 + 10'(k), 32'h0, 4'hF);
      @(negedge clk);
      chk($sformatf("lock_w%0d_m0_waitrequest", k), {31'b0, m0_waitrequest}, 32'd1);
      chk($sformatf("lock_w%0d_m1_waitrequest", k), {31'b0, m1_waitrequest}, 32'd0);
    end
    next_cycle();
    m1_lock = 1'b0;
    drive(OP_R, 10'h005, 32'h0, 4'hF, OP_I, 10'h000, 32'h0, 4'h0);
    @(negedge clk);
    chk("lock_release_m0_waitrequest", {31'b0, m0_waitrequest}, 32'd1);
    chk("lock_release_chipselect", {31'b0, sram_chipselect}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("lock_after_m0_granted", {31'b0, m0_waitrequest}, 32'd0);
    next_cycle();
    drive(OP_I, 10'h000, 32'h0, 4'h0, OP_I, 10'h000, 32'h0, 4'h0);
    @(negedge clk);
    chk("lock_after_m0_readdata", {m0_readdatavalid ? m0_readdata : 32'h0}, 32'hDEAD_BEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onchip_sram_port_arbiter.md
Name: onchip_sram_port_arbiter

Overview:
- Shares the second port of the 1024x32 dual-port on-chip SRAM between two Avalon-MM masters: a HPS-bridge-side master (M0) and an accelerator/DMA master (M1).
- The SRAM port presents a 1-cycle registered-address read latency. This block arbitrates per cycle, drives the port, and returns read data with readdatavalid to the owning master.
- Port 1 of the SRAM is untouched.

Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- M0_PRIORITY, 0, 0 = round-robin; 1 = M0 always wins on contention

Ports:
- clk  in  1  system clock; also clocks the SRAM
- reset_n  in  1  asynchronous active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data; both are driven from sram_readdata
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle pulse marking valid read data
- sram_address  out  ADDR_W  to SRAM address2
- sram_chipselect  out  1  to chipselect2
- sram_write  out  1  to write2
- sram_writedata  out  DATA_W  to writedata2
- sram_byteenable  out  DATA_W/8  to byteenable2
- sram_clken  out  1  to clken2; constant 1
- sram_readdata  in  DATA_W  from readdata2

Behaviour:
- Request: master i requests when mi_read or mi_write is high. If both are high, the request is treated as a write and a simulation assertion fires.
- Grant is combinational in the same cycle:
  - single requester: it is granted;
  - both requesting, round-robin: the master not granted last wins;
  - both requesting, M0_PRIORITY=1: M0 wins.
- Granted master: waitrequest=0; its address, writedata, byteenable and write drive the sram_* outputs; sram_chipselect=1.
- Losing or idle master: waitrequest=1 while it requests. When idle its waitrequest value is don't-care, and is driven 1.
- No grant: sram_chipselect=0, sram_write=0. Address and data outputs hold the M0 values (don't-care).
- Writes complete in the grant cycle.
- Reads: the grant cycle presents the address; in cycle +1, mi_readdatavalid=1 for the owner only, and data is sram_readdata.
- Reads are fully pipelined: back-to-back grants (M0 read, M1 read, M0 read...) give one readdatavalid per cycle, in grant order, to the correct owner.
- Registers:
  - last_grant (1b) updates only on a grant cycle;
  - rd_pending (1b) and rd_owner (1b) capture each read grant.
- FSM (lock state, see Optional Feature): FREE -> LOCK0/LOCK1 -> FREE. Without the feature it stays FREE.
- Reset (reset_n low, asynchronous):
  - last_grant=1, so M0 wins the first contention;
  - rd_pending=0; all readdatavalid=0; FSM=FREE.
  - While reset_n is low, all waitrequest are forced to 1 and sram_chipselect/sram_write to 0.
- Reset mid-read: the pending readdatavalid is dropped and is not re-issued after release.
- Write then read of the same address from different masters in consecutive cycles: the read returns the new data, because the SRAM port is same-port ordered.
- Address wrap: none; the full ADDR_W range is passed through.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined: adds inputs m0_lock and m1_lock (1b each).
  - A granted master with mi_lock=1 moves the FSM to LOCKi.
  - In LOCKi only master i may be granted; the other master sees waitrequest=1.
  - LOCKi returns to FREE on the first cycle master i is idle with mi_lock=0, or if the lock is deasserted on a granted cycle.
  - Simultaneous lock requests are resolved by the normal grant.
- Undefined: no lock ports, FSM constant FREE, arbitration as above.

Decomposition:
- Package sram_arb_pkg:
  - lock-state enum (FREE, LOCK0, LOCK1);
  - master-index typedef (1b);
  - localparams for the default ADDR_W and DATA_W.
- One natural sub-module: rr_arbiter2. Pure grant logic: req[1:0], last_grant and priority mode in, one-hot gnt out. Instantiated once.

Test Plan:
- Reset then single read: M0 read addr 0x005 (SRAM preloaded 0xDEADBEEF) -> waitrequest 0 in cycle 0; m0_readdatavalid=1 with 0xDEADBEEF in cycle 1; m1_readdatavalid stays 0.
- Contention, round-robin: M0 and M1 both continuously write addrs 0x010/0x020 -> grants alternate M0, M1, M0, M1; each master sees waitrequest=1 every other cycle; the SRAM holds both written values.
- Pipelined reads: M0 read 0x001, M1 read 0x002, M0 read 0x003 on consecutive grants -> readdatavalid pattern m0, m1, m0 with the matching data, one cycle after each grant.
- Byteenable and ordering: M1 writes 0xAABBCCDD to 0x3FF with byteenable 4'b0101 over 0x00000000, then M0 reads 0x3FF -> 0x00BB00DD.
- Reset mid-read: assert reset_n=0 in the cycle after an M1 read grant -> no readdatavalid is produced; after release, M0 wins the first contention.
- SRAM_ARB_LOCK_EN: M1 locks and issues 4 writes while M0 requests -> M0 waitrequest=1 throughout; M0 is granted in the cycle after M1 drops the lock.
